// File: rtl/jt49_mave_arb.sv
// Shared moving-average engine: round-robin arbitration of NCH sample streams through one
// delay RAM and per-channel running sums; each result is the floor mean of the last 2^DEPTH samples.
module jt49_mave_arb #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           i_in_valid,
    input  logic [NCH*DW-1:0]        i_in_data,
    output logic [NCH-1:0]           o_in_ready,
    input  logic                     i_flush,
    output logic                     o_busy_clr,
    output logic                     o_out_valid,
    output logic [$clog2(NCH)-1:0]   o_out_ch,
    output logic [DW-1:0]            o_out_data
);

    localparam int unsigned CW     = $clog2(NCH);
    localparam int unsigned AW     = CW + DEPTH;
    localparam int unsigned SW     = DW + DEPTH;
    localparam int unsigned NWORDS = NCH << DEPTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_UPD   = 2'd3;

    logic [1:0]     r_state;
    logic [AW-1:0]  r_clr_cnt;
    logic [CW-1:0]  r_last;
    logic [CW-1:0]  r_ch;
    logic [DW-1:0]  r_din;
    logic [DW-1:0]  r_old;
    logic [AW-1:0]  r_addr;
    logic [SW-1:0]  r_sum [NCH];
    logic [DEPTH-1:0] r_ptr [NCH];
    logic [DW-1:0]  r_ram [NWORDS];

    logic [DW-1:0]  w_data [NCH];
    logic           w_gnt_any;
    logic [CW-1:0]  w_gnt_ch;
    logic [CW-1:0]  w_idx;
    logic [SW-1:0]  w_new_sum;
    logic           w_we;
    logic [AW-1:0]  w_waddr;
    logic [DW-1:0]  w_wdata;

    for (genvar g = 0; g < NCH; g++) begin : g_split
        assign w_data[g] = i_in_data[g*DW +: DW];
    end

    // Scan from the lowest priority upwards so the last hit is the channel after r_last.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = CW'((int'(r_last) + 1 + k) % int'(NCH));
            if (i_in_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_ch  = w_idx;
            end
        end
    end

    always_comb begin
        o_in_ready = '0;
        if (r_state == S_IDLE && w_gnt_any && !rst) begin
            o_in_ready[w_gnt_ch] = 1'b1;
        end
    end

    assign o_busy_clr = (r_state == S_CLEAR);

    assign w_new_sum = r_sum[r_ch] + {{DEPTH{r_din[DW-1]}}, r_din}
                                   - {{DEPTH{r_old[DW-1]}}, r_old};

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
            end else if (r_state == S_UPD && !i_flush) begin
                w_we    = 1'b1;
                w_waddr = {r_ch, r_ptr[r_ch]};
                w_wdata = r_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_last      <= LAST_CH;
            r_ch        <= '0;
            r_din       <= '0;
            r_old       <= '0;
            r_addr      <= '0;
            o_out_valid <= 1'b0;
            o_out_ch    <= '0;
            o_out_data  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                r_sum[i] <= '0;
                r_ptr[i] <= '0;
            end
        end else begin
            o_out_valid <= 1'b0;
            if (r_state != S_CLEAR && i_flush) begin
                // Drops any in-flight sample; nothing is committed.
                r_state   <= S_CLEAR;
                r_clr_cnt <= '0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        for (int i = 0; i < int'(NCH); i++) begin
                            r_sum[i] <= '0;
                            r_ptr[i] <= '0;
                        end
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (r_clr_cnt == LAST_ADDR) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (w_gnt_any) begin
                            r_ch    <= w_gnt_ch;
                            r_din   <= w_data[w_gnt_ch];
                            r_addr  <= {w_gnt_ch, r_ptr[w_gnt_ch]};
                            r_state <= S_RD;
                        end
                    end
                    S_RD: begin
                        r_old   <= r_ram[r_addr];
                        r_state <= S_UPD;
                    end
                    S_UPD: begin
                        r_sum[r_ch] <= w_new_sum;
                        r_ptr[r_ch] <= r_ptr[r_ch] + 1'b1;
                        r_last      <= r_ch;
                        o_out_valid <= 1'b1;
                        o_out_ch    <= r_ch;
                        o_out_data  <= w_new_sum[SW-1:DEPTH];
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_CLEAR;
                endcase
            end
        end
    end

endmodule
